// File: rtl/burst_mem_responder.sv
// ---------------------------------------------------------------------------
// burst_mem_responder
//
// Line-oriented memory responder for a 64-bit, 4-beat burst port. Storage is
// 2^INDEX_BITS lines of 32 bytes, kept as four 64-bit words per line. One
// read or write line transfer is serviced at a time. The first beat appears
// READ_LATENCY / WRITE_LATENCY cycles after the request is sampled.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   reset          - synchronous, active-high; aborts any transfer in flight,
//                    leaves storage contents untouched
//   mem_read       - line read request, held until the burst completes
//   mem_write      - line write request, held until the burst completes
//   mem_addr       - byte address of the line; [4:0] ignored, upper bits alias
//   mem_wdata      - write beat, advanced by the initiator after each resp edge
//   mem_rdata      - read beat, valid only while mem_resp is high on a read
//   mem_resp       - beat strobe, high for exactly 4 consecutive cycles
//   protocol_error - sticky flag, cleared only by reset
// ---------------------------------------------------------------------------
module burst_mem_responder #(
  parameter int INDEX_BITS    = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic [63:0] mem_rdata,
  output logic        mem_resp,
  output logic        protocol_error
);

  localparam int WORDS     = (1 << INDEX_BITS) * 4;
  localparam int WADDR_W   = INDEX_BITS + 2;

  // The counter is loaded with latency-1 on the sampling edge; WAIT then
  // spends latency-1 further edges counting down plus one edge to enter
  // BURST, so the first resp cycle lands exactly latency cycles later.
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

  state_t                  state, state_next;
  logic [1:0]              beat, beat_next;
  logic [1:0]              beat_inc;
  logic [3:0]              count, count_next;
  logic                    op_write, op_write_next;
  logic [INDEX_BITS-1:0]   index, index_next;
  logic                    resp_next;
  logic [63:0]             rdata_next;
  logic                    error_next;
  logic                    mem_we;
  logic [WADDR_W-1:0]      rd_addr;
  logic [WADDR_W-1:0]      wr_addr;
  logic                    request;

  logic [63:0]             storage [WORDS];

  // Address bits outside the line index are deliberately ignored.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:5+INDEX_BITS], mem_addr[4:0]};

  assign request  = mem_read | mem_write;
  assign beat_inc = beat + 2'd1;
  assign wr_addr  = {index, beat};

  // The read word is fetched one cycle ahead so that mem_rdata is registered
  // and rises together with mem_resp: word 0 while leaving WAIT, the next
  // beat's word while stepping through BURST.
  assign rd_addr  = (state == WAIT) ? {index, 2'b00} : {index, beat_inc};

  // Next-state logic and the registered-output next values.
  always_comb begin
    state_next    = state;
    beat_next     = beat;
    count_next    = count;
    op_write_next = op_write;
    index_next    = index;
    resp_next     = 1'b0;
    rdata_next    = '0;
    error_next    = protocol_error;
    mem_we        = 1'b0;

    case (state)
      IDLE: begin
        if (request) begin
          // A simultaneous read and write is serviced as a write.
          op_write_next = mem_write;
          index_next    = mem_addr[5 +: INDEX_BITS];
          beat_next     = 2'd0;
          count_next    = mem_write ? WR_LOAD : RD_LOAD;
          state_next    = WAIT;
          if (mem_read && mem_write) begin
            error_next = 1'b1;
          end
        end
      end

      WAIT: begin
        if (!request) begin
          error_next = 1'b1;
        end
        if (count == 4'd0) begin
          state_next = BURST;
          beat_next  = 2'd0;
          resp_next  = 1'b1;
          rdata_next = op_write ? 64'd0 : storage[rd_addr];
        end else begin
          count_next = count - 4'd1;
        end
      end

      BURST: begin
        // A dropped request is flagged but the burst still runs to beat 3.
        if (!request) begin
          error_next = 1'b1;
        end
        mem_we = op_write;
        if (beat == 2'd3) begin
          state_next = DONE;
        end else begin
          beat_next  = beat_inc;
          resp_next  = 1'b1;
          rdata_next = op_write ? 64'd0 : storage[rd_addr];
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves the storage array alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      beat           <= 2'd0;
      count          <= 4'd0;
      op_write       <= 1'b0;
      index          <= '0;
      mem_resp       <= 1'b0;
      mem_rdata      <= 64'd0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_next;
      beat           <= beat_next;
      count          <= count_next;
      op_write       <= op_write_next;
      index          <= index_next;
      mem_resp       <= resp_next;
      mem_rdata      <= rdata_next;
      protocol_error <= error_next;
    end
  end

  // Line storage. A reset on the same edge as a write beat suppresses that
  // beat, so an aborted burst commits only the beats before the reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      storage[wr_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_responder
//
// Directed bench for burst_mem_responder with default parameters. A line
// model tracks what storage should hold; reads push the expected beats onto
// a scoreboard queue when the request is driven and pop them as resp beats
// arrive.
// ---------------------------------------------------------------------------
module tb_burst_mem_responder;

  localparam int INDEX_BITS    = 8;
  localparam int READ_LATENCY  = 4;
  localparam int WRITE_LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [(1 << INDEX_BITS) * 4];
  logic [63:0] exp_q [$];
  bit          exp_err;

  burst_mem_responder #(
    .INDEX_BITS    (INDEX_BITS),
    .READ_LATENCY  (READ_LATENCY),
    .WRITE_LATENCY (WRITE_LATENCY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .protocol_error (protocol_error)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lineIndex(input logic [31:0] addr);
    return int'(addr >> 5) & ((1 << INDEX_BITS) - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits for the first resp beat and checks how many cycles it took.
  task automatic waitForResp(input string tag, input int expect_lat, output bit ok);
    int cyc;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < 40 && !ok) begin
      @(negedge clk);
      cyc++;
      if (mem_resp === 1'b1) ok = 1'b1;
    end
    if (ok) checkOutput({tag, "_latency"}, 64'(cyc - 1), 64'(expect_lat));
    else    checkOutput({tag, "_resp_timeout"}, 64'(mem_resp), 64'd1);
  endtask

  // One complete line transfer, started from an IDLE cycle at a negedge.
  // wline holds beat 0 in [63:0] ... beat 3 in [255:192].
  // drop_after >= 0 drops the request during that beat; reset_at >= 0
  // asserts reset during that beat.
  task automatic applyStimulus(input string tag, input logic [31:0] addr,
                               input bit do_read, input bit do_write,
                               input logic [255:0] wline,
                               input int drop_after, input int reset_at);
    bit          is_write;
    int          idx;
    bit          ok;
    logic [63:0] expected;
    is_write = do_write;
    idx      = lineIndex(addr);
    if (do_read && do_write) exp_err = 1'b1;
    if (!is_write) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(model[idx * 4 + b]);
    end
    mem_addr  = addr;
    mem_read  = do_read;
    mem_write = do_write;
    mem_wdata = wline[63:0];
    waitForResp(tag, is_write ? WRITE_LATENCY : READ_LATENCY, ok);
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        if (b > 0) @(negedge clk);
        checkOutput($sformatf("%s_resp_beat%0d", tag, b), 64'(mem_resp), 64'd1);
        if (is_write) begin
          checkOutput($sformatf("%s_wr_rdata_beat%0d", tag, b), mem_rdata, 64'd0);
          mem_wdata = wline[64 * b +: 64];
        end else begin
          expected = exp_q.pop_front();
          checkOutput($sformatf("%s_rdata_beat%0d", tag, b), mem_rdata, expected);
        end
        if (b == drop_after) begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
          exp_err   = 1'b1;
        end
        if (b == reset_at) begin
          reset = 1'b1;
          break;
        end
        if (is_write) model[idx * 4 + b] = wline[64 * b +: 64];
      end
      @(negedge clk);
      checkOutput({tag, "_end_resp"}, 64'(mem_resp), 64'd0);
      checkOutput({tag, "_end_rdata"}, mem_rdata, 64'd0);
      if (reset_at >= 0) begin
        reset   = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
      end
      checkOutput({tag, "_protocol_error"}, 64'(protocol_error), 64'(exp_err));
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_resp"}, 64'(mem_resp), 64'd0);
    checkOutput({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] line_c;
    logic [255:0] line_old;
    logic [255:0] line_new;
    logic [255:0] line_r;

    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 64'd0;
    exp_err   = 1'b0;

    line_a   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b   = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    line_c   = {64'h0123_4567_89AB_CDE3, 64'h0123_4567_89AB_CDE2,
                64'h0123_4567_89AB_CDE1, 64'h0123_4567_89AB_CDE0};
    line_old = {64'h0DD0_0DD0_0DD0_0003, 64'h0DD0_0DD0_0DD0_0002,
                64'h0DD0_0DD0_0DD0_0001, 64'h0DD0_0DD0_0DD0_0000};
    line_new = {64'hFEED_FEED_FEED_0003, 64'hFEED_FEED_FEED_0002,
                64'hFEED_FEED_FEED_0001, 64'hFEED_FEED_FEED_0000};

    $display("[TB] reset phase");
    repeat (3) @(negedge clk);
    checkOutput("reset_resp", 64'(mem_resp), 64'd0);
    checkOutput("reset_rdata", mem_rdata, 64'd0);
    checkOutput("reset_protocol_error", 64'(protocol_error), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic write then read of line 0x40");
    applyStimulus("wr40", 32'h0000_0040, 1'b0, 1'b1, line_a, -1, -1);
    applyStimulus("rd40", 32'h0000_0040, 1'b1, 1'b0, '0, -1, -1);

    $display("[TB] aliasing through 0x2040 / 0x205F");
    applyStimulus("wr2040", 32'h0000_2040, 1'b0, 1'b1, line_b, -1, -1);
    applyStimulus("rd40_alias", 32'h0000_0040, 1'b1, 1'b0, '0, -1, -1);
    applyStimulus("rd205F_alias", 32'h0000_205F, 1'b1, 1'b0, '0, -1, -1);

    $display("[TB] read and write together at 0x80");
    applyStimulus("both80", 32'h0000_0080, 1'b1, 1'b1, line_c, -1, -1);
    applyStimulus("rd80", 32'h0000_0080, 1'b1, 1'b0, '0, -1, -1);
    applyStimulus("wr100_sticky", 32'h0000_0100, 1'b0, 1'b1, line_a, -1, -1);
    applyStimulus("rd100_sticky", 32'h0000_0100, 1'b1, 1'b0, '0, -1, -1);

    $display("[TB] request dropped after beat 1");
    applyStimulus("rd40_drop", 32'h0000_0040, 1'b1, 1'b0, '0, 1, -1);

    $display("[TB] reset during beat 2 of a write");
    applyStimulus("wrC0_old", 32'h0000_00C0, 1'b0, 1'b1, line_old, -1, -1);
    applyStimulus("wrC0_reset", 32'h0000_00C0, 1'b0, 1'b1, line_new, -1, 2);
    applyStimulus("rdC0_after_reset", 32'h0000_00C0, 1'b1, 1'b0, '0, -1, -1);

    $display("[TB] scattered lines with varied data");
    for (int n = 0; n < 3; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 65535), 16'h0000} | (32'(n + 8) << 5) | 32'(n * 7);
      for (int b = 0; b < 4; b++) line_r[64 * b +: 64] = {$urandom, $urandom};
      applyStimulus($sformatf("wr_rand%0d", n), a, 1'b0, 1'b1, line_r, -1, -1);
      applyStimulus($sformatf("rd_rand%0d", n), a, 1'b1, 1'b0, '0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
